serv_alu_seq: RTL and testbench
===============================

SERV_ALU_SEQ -- requirements
Module: serv_alu_seq

Interface
REQ-001 Parameter LEN, default 32: operand/result width in bits, equal to the number of ALU cycles per pass; legal range 2..32.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_req_valid  in  1; o_req_ready  out  1: request handshake.
REQ-005 i_op  in  3  operation: 000 ADD, 001 SUB, 010 SLT, 011 SLTU, 100 XOR, 101 OR, 110 AND, 111 EQ.
REQ-006 i_rs1, i_op_b  in  LEN  parallel operands.
REQ-007 o_res_valid  out  1; i_res_ready  in  1: result handshake.
REQ-008 o_res  out  LEN  result; o_cmp  out  1  compare flag.
REQ-009 ALU-side outputs: o_alu_en (1), o_alu_cnt0 (1), o_alu_sub (1), o_alu_bool_op (2), o_alu_cmp_eq (1), o_alu_cmp_sig (1), o_alu_rd_sel (3), o_alu_rs1 (1), o_alu_op_b (1), o_alu_buf (1).
REQ-010 ALU-side inputs: i_alu_rd (1) serial result, i_alu_cmp (1) compare output.

Function
REQ-011 States: IDLE, SETUP, RUN1, GAP, RUN2, DONE; a cycle counter cnt runs 0..LEN-1.
REQ-012 o_req_ready = 1 only in IDLE; acceptance when i_req_valid & o_req_ready; i_op, i_rs1, i_op_b latched only on acceptance.
REQ-013 Transitions:
- IDLE->SETUP on acceptance.
- SETUP->RUN1 after 1 cycle.
- RUN1 (LEN cycles) -> GAP for SLT/SLTU/EQ, else -> DONE.
- GAP->RUN2 after 1 cycle.
- RUN2 (LEN cycles) -> DONE.
- DONE->IDLE when i_res_ready.
REQ-014 SETUP and GAP drive o_alu_en=0 and o_alu_sub at the op's value, so the ALU preloads its carry (1 for SUB/SLT/SLTU/EQ).
REQ-015 RUN1 and RUN2 drive o_alu_en=1; o_alu_cnt0=1 only when cnt==0.
REQ-016 RUN1 operand streaming:
- o_alu_rs1/o_alu_op_b = bit 0 of internal shift registers.
- Both registers shift right once per RUN1 cycle, so operands go LSB first.
REQ-017 RUN1 controls:
- ADD: sub=0, rd_sel=001.
- SUB: sub=1, rd_sel=001.
- XOR/OR/AND: rd_sel=100, bool_op=00/10/11.
- SLT: sub=1, cmp_sig=1, cmp_eq=0, rd_sel=000.
- SLTU: as SLT with cmp_sig=0.
- EQ: sub=1, cmp_eq=1, rd_sel=000.
- bool_op=01 for all non-boolean ops.
REQ-018 RUN2 drives rd_sel=010 with o_alu_rs1=o_alu_op_b=0.
REQ-019 Result capture:
- Each RUN1 cycle of ADD/SUB/boolean ops shifts i_alu_rd into the result register MSB, so after LEN cycles o_res holds the bit-parallel result.
- Each RUN2 cycle does the same capture, giving o_res = {LEN-1 zeros, compare bit}.
REQ-020 o_cmp is registered from i_alu_cmp on the cycle cnt==LEN-1 of RUN1 for SLT/SLTU/EQ, and is 0 for other ops.
REQ-021 o_alu_buf is constant 0; all ALU control outputs are 0 in IDLE and DONE.
REQ-022 o_res_valid = 1 only in DONE; o_res and o_cmp stay stable while o_res_valid & !i_res_ready.
REQ-023 Latency, with acceptance at cycle T:
- ADD/SUB/boolean ops: o_res_valid first high at T+LEN+2.
- SLT/SLTU/EQ: o_res_valid first high at T+2*LEN+3.
REQ-024 A new request is never accepted in the same cycle as a result handshake; the earliest next acceptance is the cycle after DONE->IDLE.
REQ-025 Requests presented while busy are held off (o_req_ready=0) with no state effect.
REQ-026 Arithmetic wraps modulo 2^LEN; there are no overflow flags.

Reset
REQ-027 While i_rst_n=0:
- State = IDLE, cnt=0.
- o_res=0, o_cmp=0, o_res_valid=0.
- All o_alu_* outputs = 0.
- o_req_ready=1.
REQ-028 Reset asserted mid-operation aborts it immediately: no result is produced and no o_res_valid pulse follows deassertion.

Verification
REQ-029 ADD 5+7, i_res_ready=1 -> o_res=0x0000000C, o_cmp=0, o_res_valid at T+34 (LEN=32).
REQ-030 SUB 3-5 -> o_res=0xFFFFFFFE at T+34; o_alu_sub=1 during SETUP.
REQ-031 SLT rs1=0xFFFFFFFF, op_b=1 -> o_res=1, o_cmp=1 at T+67; SLTU with the same operands -> o_res=0, o_cmp=0.
REQ-032 EQ 0x1234, 0x1234 -> o_res=1, o_cmp=1; EQ 0x1234, 0x1235 -> o_res=0, o_cmp=0.
REQ-033 AND 0xF0F0F0F0 & 0xFF00FF00 with i_res_ready=0 for 10 cycles -> o_res=0xF000F000 held stable, o_req_ready=0 throughout, return to IDLE one cycle after i_res_ready=1.
REQ-034 Reset pulsed at cnt=10 of RUN1 -> all outputs 0, o_req_ready=1, no o_res_valid afterwards, next ADD 1+1 -> o_res=2.

Source files
------------

// File: rtl/serv_alu_seq.sv
// Sequencer that feeds a bit-serial SERV-style ALU LSB first and reassembles its serial result.
// Compare ops take a second pass so the ALU can emit its stored compare bit as bit 0 of rd.
module serv_alu_seq #(
   parameter int unsigned LEN = 32
) (
   input  logic           clk,
   input  logic           i_rst_n,
   input  logic           i_req_valid,
   output logic           o_req_ready,
   input  logic [2:0]     i_op,
   input  logic [LEN-1:0] i_rs1,
   input  logic [LEN-1:0] i_op_b,
   output logic           o_res_valid,
   input  logic           i_res_ready,
   output logic [LEN-1:0] o_res,
   output logic           o_cmp,
   output logic           o_alu_en,
   output logic           o_alu_cnt0,
   output logic           o_alu_sub,
   output logic [1:0]     o_alu_bool_op,
   output logic           o_alu_cmp_eq,
   output logic           o_alu_cmp_sig,
   output logic [2:0]     o_alu_rd_sel,
   output logic           o_alu_rs1,
   output logic           o_alu_op_b,
   output logic           o_alu_buf,
   input  logic           i_alu_rd,
   input  logic           i_alu_cmp
);

   localparam int unsigned CW = (LEN > 2) ? $clog2(LEN) : 1;

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpSlt  = 3'b010;
   localparam logic [2:0] OpSltu = 3'b011;
   localparam logic [2:0] OpXor  = 3'b100;
   localparam logic [2:0] OpOr   = 3'b101;
   localparam logic [2:0] OpAnd  = 3'b110;
   localparam logic [2:0] OpEq   = 3'b111;

   typedef enum logic [2:0] {
      StIdle, StSetup, StRun1, StGap, StRun2, StDone
   } state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [2:0]     r_op;
   logic [LEN-1:0] r_rs1;
   logic [LEN-1:0] r_op_b;
   logic [LEN-1:0] r_res;
   logic           r_cmp;

   logic w_accept;
   logic w_last;
   logic w_is_cmp;
   logic w_is_bool;
   logic w_sub;
   logic w_run;

   assign w_accept  = i_req_valid && (r_state == StIdle);
   assign w_last    = (r_cnt == CW'(LEN - 1));
   assign w_is_cmp  = (r_op == OpSlt) || (r_op == OpSltu) || (r_op == OpEq);
   assign w_is_bool = (r_op == OpXor) || (r_op == OpOr) || (r_op == OpAnd);
   assign w_sub     = (r_op == OpSub) || w_is_cmp;
   assign w_run     = (r_state == StRun1) || (r_state == StRun2);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_op    <= OpAdd;
         r_rs1   <= '0;
         r_op_b  <= '0;
         r_res   <= '0;
         r_cmp   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_op    <= i_op;
                  r_rs1   <= i_rs1;
                  r_op_b  <= i_op_b;
                  r_cmp   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= StSetup;
               end
            end
            StSetup: r_state <= StRun1;
            StRun1: begin
               r_rs1  <= r_rs1 >> 1;
               r_op_b <= r_op_b >> 1;
               // Compare ops discard the pass-1 rd stream; their result comes from pass 2.
               if (!w_is_cmp) r_res <= {i_alu_rd, r_res[LEN-1:1]};
               if (w_last) begin
                  r_cnt <= '0;
                  if (w_is_cmp) begin
                     r_cmp   <= i_alu_cmp;
                     r_state <= StGap;
                  end else begin
                     r_state <= StDone;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StGap: r_state <= StRun2;
            StRun2: begin
               r_res <= {i_alu_rd, r_res[LEN-1:1]};
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= StDone;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StDone: if (i_res_ready) r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      o_alu_en      = w_run;
      o_alu_cnt0    = w_run && (r_cnt == '0);
      o_alu_sub     = 1'b0;
      o_alu_bool_op = 2'b00;
      o_alu_cmp_eq  = 1'b0;
      o_alu_cmp_sig = 1'b0;
      o_alu_rd_sel  = 3'b000;
      o_alu_rs1     = 1'b0;
      o_alu_op_b    = 1'b0;
      unique case (r_state)
         StSetup, StGap: o_alu_sub = w_sub;
         StRun1: begin
            o_alu_sub     = w_sub;
            o_alu_cmp_eq  = (r_op == OpEq);
            o_alu_cmp_sig = (r_op == OpSlt);
            o_alu_rs1     = r_rs1[0];
            o_alu_op_b    = r_op_b[0];
            if (w_is_bool) o_alu_rd_sel = 3'b100;
            else if (!w_is_cmp) o_alu_rd_sel = 3'b001;
            unique case (r_op)
               OpXor:   o_alu_bool_op = 2'b00;
               OpOr:    o_alu_bool_op = 2'b10;
               OpAnd:   o_alu_bool_op = 2'b11;
               default: o_alu_bool_op = 2'b01;
            endcase
         end
         StRun2: o_alu_rd_sel = 3'b010;
         default: ;
      endcase
   end

   assign o_alu_buf   = 1'b0;
   assign o_req_ready = (r_state == StIdle);
   assign o_res_valid = (r_state == StDone);
   assign o_res       = r_res;
   assign o_cmp       = r_cmp;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Directed bench for serv_alu_seq; a behavioural serial ALU closes the loop on the o_alu_* bus.
module tb_serv_alu_seq;

   logic        clk;
   logic        i_rst_n;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [2:0]  i_op;
   logic [31:0] i_rs1;
   logic [31:0] i_op_b;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [31:0] o_res;
   logic        o_cmp;
   logic        o_alu_en;
   logic        o_alu_cnt0;
   logic        o_alu_sub;
   logic [1:0]  o_alu_bool_op;
   logic        o_alu_cmp_eq;
   logic        o_alu_cmp_sig;
   logic [2:0]  o_alu_rd_sel;
   logic        o_alu_rs1;
   logic        o_alu_op_b;
   logic        o_alu_buf;
   logic        i_alu_rd;
   logic        i_alu_cmp;

   int n_checks = 0;
   int n_errors = 0;

   serv_alu_seq #(.LEN(32)) u_dut (
      .clk           (clk),
      .i_rst_n       (i_rst_n),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_op          (i_op),
      .i_rs1         (i_rs1),
      .i_op_b        (i_op_b),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_res         (o_res),
      .o_cmp         (o_cmp),
      .o_alu_en      (o_alu_en),
      .o_alu_cnt0    (o_alu_cnt0),
      .o_alu_sub     (o_alu_sub),
      .o_alu_bool_op (o_alu_bool_op),
      .o_alu_cmp_eq  (o_alu_cmp_eq),
      .o_alu_cmp_sig (o_alu_cmp_sig),
      .o_alu_rd_sel  (o_alu_rd_sel),
      .o_alu_rs1     (o_alu_rs1),
      .o_alu_op_b    (o_alu_op_b),
      .o_alu_buf     (o_alu_buf),
      .i_alu_rd      (i_alu_rd),
      .i_alu_cmp     (i_alu_cmp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serial ALU model: carry preloads from sub while disabled, cmp_r holds the last compare bit.
   logic m_cy, m_cmp_r, m_b, m_sum, m_cyo, m_lt, m_eq, m_bool;
   always_comb begin
      m_b    = o_alu_op_b ^ o_alu_sub;
      m_sum  = o_alu_rs1 ^ m_b ^ m_cy;
      m_cyo  = (o_alu_rs1 & m_b) | (m_cy & (o_alu_rs1 ^ m_b));
      m_lt   = (o_alu_cmp_sig & o_alu_rs1) ^ ~(o_alu_cmp_sig & o_alu_op_b) ^ m_cyo;
      m_eq   = ~m_sum & (o_alu_cnt0 | m_cmp_r);
      m_bool = 1'b0;
      unique case (o_alu_bool_op)
         2'b00:   m_bool = o_alu_rs1 ^ o_alu_op_b;
         2'b10:   m_bool = o_alu_rs1 | o_alu_op_b;
         2'b11:   m_bool = o_alu_rs1 & o_alu_op_b;
         default: m_bool = 1'b0;
      endcase
      i_alu_cmp = o_alu_cmp_eq ? m_eq : m_lt;
      i_alu_rd  = (o_alu_rd_sel[0] & m_sum) | (o_alu_rd_sel[1] & m_cmp_r & o_alu_cnt0)
                | (o_alu_rd_sel[2] & m_bool);
   end

   always @(posedge clk) begin
      if (o_alu_en) begin
         m_cy    <= m_cyo;
         m_cmp_r <= i_alu_cmp;
      end else begin
         m_cy <= o_alu_sub;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] alu_bus();
      return {o_alu_en, o_alu_cnt0, o_alu_sub, o_alu_bool_op, o_alu_cmp_eq, o_alu_cmp_sig,
              o_alu_rd_sel, o_alu_rs1, o_alu_op_b, o_alu_buf};
   endfunction

   // Issues one request and checks latency, setup controls and result; leaves DUT in DONE
   // when i_res_ready is low, otherwise back in IDLE.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_cmp,
                         input int exp_lat, input logic exp_sub, input logic [2:0] exp_rdsel);
      int lat;
      @(negedge clk);
      check({tag, ":ready_idle"}, 32'(o_req_ready), 32'd1);
      i_req_valid = 1'b1;
      i_op        = op;
      i_rs1       = a;
      i_op_b      = b;
      lat         = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            i_req_valid = 1'b0;
            check({tag, ":setup_sub_en"}, {30'd0, o_alu_sub, o_alu_en}, {30'd0, exp_sub, 1'b0});
            check({tag, ":busy_ready"}, 32'(o_req_ready), 32'd0);
         end
         if (lat == 2) check({tag, ":run1_first"}, {27'd0, o_alu_en, o_alu_cnt0, o_alu_rd_sel},
                             {27'd0, 1'b1, 1'b1, exp_rdsel});
         if (lat == 3) check({tag, ":run1_cnt0"}, 32'(o_alu_cnt0), 32'd0);
      end while (!o_res_valid && lat < 200);
      check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ":res"}, o_res, exp_res);
      check({tag, ":cmp"}, 32'(o_cmp), 32'(exp_cmp));
      if (i_res_ready) begin
         check({tag, ":no_accept_in_done"}, 32'(o_req_ready), 32'd0);
         @(posedge clk);
         #1;
         check({tag, ":back_idle"}, {30'd0, o_req_ready, o_res_valid}, 32'd2);
      end
   endtask

   initial begin
      int lat;
      int hits;
      i_rst_n     = 1'b0;
      i_req_valid = 1'b0;
      i_op        = 3'd0;
      i_rs1       = '0;
      i_op_b      = '0;
      i_res_ready = 1'b1;
      #2;
      check("rst_res", o_res, 32'd0);
      check("rst_flags", {29'd0, o_cmp, o_res_valid, o_req_ready}, 32'd1);
      check("rst_alu", 32'(alu_bus()), 32'd0);
      repeat (2) @(negedge clk);
      i_rst_n = 1'b1;

      run_op("add", 3'b000, 32'd5, 32'd7, 32'h0000000C, 1'b0, 34, 1'b0, 3'b001);
      run_op("sub", 3'b001, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 34, 1'b1, 3'b001);
      run_op("slt", 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, 67, 1'b1, 3'b000);
      run_op("sltu", 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 67, 1'b1, 3'b000);
      run_op("slt_pos", 3'b010, 32'd5, 32'd7, 32'd1, 1'b1, 67, 1'b1, 3'b000);
      run_op("slt_gt", 3'b010, 32'd7, 32'd5, 32'd0, 1'b0, 67, 1'b1, 3'b000);
      run_op("eq_hit", 3'b111, 32'h1234, 32'h1234, 32'd1, 1'b1, 67, 1'b1, 3'b000);
      run_op("eq_miss", 3'b111, 32'h1234, 32'h1235, 32'd0, 1'b0, 67, 1'b1, 3'b000);
      run_op("xor", 3'b100, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 34, 1'b0, 3'b100);
      run_op("or", 3'b101, 32'h0F00F000, 32'h00F0000F, 32'h0FF0F00F, 1'b0, 34, 1'b0, 3'b100);
      run_op("add_wrap", 3'b000, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 34, 1'b0, 3'b001);

      // Back-pressure on the result side.
      i_res_ready = 1'b0;
      run_op("and", 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 34, 1'b0, 3'b100);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_res", o_res, 32'hF000F000);
         check("hold_flags", {29'd0, o_cmp, o_res_valid, o_req_ready}, 32'd2);
      end
      @(negedge clk);
      i_res_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold_release", {30'd0, o_req_ready, o_res_valid}, 32'd2);

      // Abort mid RUN1 at cnt=10.
      @(negedge clk);
      i_req_valid = 1'b1;
      i_op        = 3'b000;
      i_rs1       = 32'd100;
      i_op_b      = 32'd200;
      lat         = 0;
      while (lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
         i_req_valid = 1'b0;
      end
      i_rst_n = 1'b0;
      #1;
      check("abort_res", o_res, 32'd0);
      check("abort_flags", {29'd0, o_cmp, o_res_valid, o_req_ready}, 32'd1);
      check("abort_alu", 32'(alu_bus()), 32'd0);
      @(negedge clk);
      i_rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (o_res_valid) hits++;
      end
      check("abort_no_valid", 32'(hits), 32'd0);
      run_op("add_after", 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 34, 1'b0, 3'b001);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
